// File: rtl/store_aligner_pkg.sv
// Shared store-path types: access size encoding, store FSM states,
// and the size-to-byte-count helper.
package HighLevelControl;

    typedef enum logic [2:0] {
        NO_TRUNC,
        BYTE,
        HALF_WORD,
        WORD,
        BYTE_UNSIGNED,
        HALF_WORD_UNSIGNED,
        WORD_UNSIGNED
    } truncSrc;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } storeState_t;

    // Unsigned variants store the same number of bytes as their signed forms.
    function automatic int unsigned storeBytes(
        input truncSrc     s,
        input int unsigned nb = 4
    );
        case (s)
            BYTE, BYTE_UNSIGNED:           return 1;
            HALF_WORD, HALF_WORD_UNSIGNED: return 2;
            WORD, WORD_UNSIGNED:           return 4;
            default:                       return nb;
        endcase
    endfunction

endpackage

// File: rtl/store_aligner_lane_shifter.sv
// Places the low size bytes of a store onto the word lanes; beat 1
// selects the lanes that spill past the end of the first word.
module store_lane_shifter #(
    parameter  int BIT_COUNT = 32,
    localparam int NB        = BIT_COUNT / 8,
    localparam int OFS       = $clog2(NB)
) (
    input  logic [OFS:0]           size,
    input  logic [OFS-1:0]         offset,
    input  logic [BIT_COUNT-1:0]   data,
    input  logic                   beat,
    output logic [BIT_COUNT-1:0]   lane_data,
    output logic [NB-1:0]          byte_en
);

    logic [NB-1:0]          size_mask;
    logic [BIT_COUNT-1:0]   masked;
    logic [2*BIT_COUNT-1:0] wide_data;
    logic [2*NB-1:0]        wide_be;

    // Shift into a double-width window; the upper half is the spill beat.
    always_comb begin
        size_mask = '0;
        masked    = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i]     = (i < int'(size));
            masked[8*i +: 8] = size_mask[i] ? data[8*i +: 8] : 8'h00;
        end
        wide_data = {{BIT_COUNT{1'b0}}, masked} << {offset, 3'b000};
        wide_be   = {{NB{1'b0}}, size_mask} << offset;
        lane_data = beat ? wide_data[2*BIT_COUNT-1:BIT_COUNT]
                         : wide_data[BIT_COUNT-1:0];
        byte_en   = beat ? wide_be[2*NB-1:NB] : wide_be[NB-1:0];
    end

endmodule

// File: rtl/store_aligner.sv
// Memory-stage store aligner: one or two byte-enabled beats per store.
// Define MISALIGNED_SPLIT_EN to split crossing stores instead of faulting.
module store_aligner
    import HighLevelControl::*;
#(
    parameter int BIT_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StoreValid,
    output logic                 StoreReady,
    input  truncSrc              StoreSize,
    input  logic [BIT_COUNT-1:0] Address,
    input  logic [BIT_COUNT-1:0] StoreData,
    output logic                 MemValid,
    input  logic                 MemReady,
    output logic [BIT_COUNT-1:0] MemAddress,
    output logic [BIT_COUNT-1:0] MemWriteData,
    output logic [BIT_COUNT/8-1:0] MemByteEnable,
    output logic                 MisalignedFault,
    output logic                 Busy
);

    localparam int NB  = BIT_COUNT / 8;
    localparam int OFS = $clog2(NB);
    localparam int SW  = OFS + 1;

    storeState_t state, next_state;

    logic [SW-1:0]        req_size;
    logic [OFS-1:0]       req_off;
    logic [BIT_COUNT-1:0] req_data;
    logic                 req_cross;

    logic [SW-1:0]        in_size;
    logic [OFS-1:0]       in_off;
    logic [BIT_COUNT-1:0] in_base;
    logic                 in_cross;
    logic                 accept;
    logic                 drop;

    logic [SW-1:0]        sh_size;
    logic [OFS-1:0]       sh_off;
    logic [BIT_COUNT-1:0] sh_data;
    logic                 sh_beat;
    logic [BIT_COUNT-1:0] lane_data;
    logic [NB-1:0]        lane_be;

    assign in_size  = SW'(storeBytes(StoreSize, NB));
    assign in_off   = Address[OFS-1:0];
    assign in_base  = {Address[BIT_COUNT-1:OFS], {OFS{1'b0}}};
    assign in_cross = (int'(in_off) + int'(in_size)) > NB;
    assign accept   = StoreValid && StoreReady;

`ifdef MISALIGNED_SPLIT_EN
    assign drop = 1'b0;
`else
    logic in_misal;
    assign in_misal = ({1'b0, in_off} & (in_size - SW'(1))) != '0;
    assign drop     = in_misal;
`endif

    assign StoreReady = (state == IDLE);
    assign Busy       = (state != IDLE);
    assign MemValid   = (state != IDLE);

    // Idle shifts the live request for beat 0; BEAT0 reuses it for the spill.
    assign sh_beat = (state == BEAT0);
    assign sh_size = sh_beat ? req_size : in_size;
    assign sh_off  = sh_beat ? req_off  : in_off;
    assign sh_data = sh_beat ? req_data : StoreData;

    store_lane_shifter #(
        .BIT_COUNT (BIT_COUNT)
    ) u_shift (
        .size      (sh_size),
        .offset    (sh_off),
        .data      (sh_data),
        .beat      (sh_beat),
        .lane_data (lane_data),
        .byte_en   (lane_be)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept && !drop) next_state = BEAT0;
            BEAT0: if (MemReady) next_state = req_cross ? BEAT1 : IDLE;
            BEAT1: if (MemReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MemAddress      <= '0;
            MemWriteData    <= '0;
            MemByteEnable   <= '0;
            MisalignedFault <= 1'b0;
            req_size        <= '0;
            req_off         <= '0;
            req_data        <= '0;
            req_cross       <= 1'b0;
        end else begin
`ifdef MISALIGNED_SPLIT_EN
            MisalignedFault <= 1'b0;
`else
            MisalignedFault <= accept && in_misal;
`endif
            case (state)
                IDLE: begin
                    if (accept && !drop) begin
                        MemAddress    <= in_base;
                        MemWriteData  <= lane_data;
                        MemByteEnable <= lane_be;
                        req_size      <= in_size;
                        req_off       <= in_off;
                        req_data      <= StoreData;
                        req_cross     <= in_cross;
                    end
                end
                BEAT0: begin
                    if (MemReady) begin
                        if (req_cross) begin
                            MemAddress    <= MemAddress + BIT_COUNT'(NB);
                            MemWriteData  <= lane_data;
                            MemByteEnable <= lane_be;
                        end else begin
                            MemAddress    <= '0;
                            MemWriteData  <= '0;
                            MemByteEnable <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (MemReady) begin
                        MemAddress    <= '0;
                        MemWriteData  <= '0;
                        MemByteEnable <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Self-checking bench for store_aligner: vector table feeding a beat
// scoreboard, plus stall, reset and fault sequences.
module tb_store_aligner;
    import HighLevelControl::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        StoreValid;
    logic        StoreReady;
    truncSrc     StoreSize;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic        MemValid;
    logic        MemReady;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [3:0]  MemByteEnable;
    logic        MisalignedFault;
    logic        Busy;

    always #5 clk = ~clk;

    store_aligner #(.BIT_COUNT(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .StoreValid      (StoreValid),
        .StoreReady      (StoreReady),
        .StoreSize       (StoreSize),
        .Address         (Address),
        .StoreData       (StoreData),
        .MemValid        (MemValid),
        .MemReady        (MemReady),
        .MemAddress      (MemAddress),
        .MemWriteData    (MemWriteData),
        .MemByteEnable   (MemByteEnable),
        .MisalignedFault (MisalignedFault),
        .Busy            (Busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        truncSrc     size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        int          nbeats;
        beat_t       b0;
        beat_t       b1;
    } vec_t;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t sb[$];
    vec_t  vecs[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_be;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input truncSrc s, input logic [31:0] a, input logic [31:0] d,
        input logic f, input int nb,
        input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] e0,
        input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] e1);
        vec_t v;
        v.size = s; v.addr = a; v.data = d; v.fault = f; v.nbeats = nb;
        v.b0.addr = a0; v.b0.data = d0; v.b0.be = e0;
        v.b1.addr = a1; v.b1.data = d1; v.b1.be = e1;
        return v;
    endfunction

    // Beat monitor: scoreboard pop on handshake, stability while stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_addr", MemAddress, prev_addr);
                chk("hold_data", MemWriteData, prev_data);
                chk("hold_be", 32'(MemByteEnable), 32'(prev_be));
            end
            if (MemValid && MemReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat_sb_size", 32'(sb.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_addr", MemAddress, e.addr);
                    chk("beat_data", MemWriteData, e.data);
                    chk("beat_be", 32'(MemByteEnable), 32'(e.be));
                end
            end
            prev_stall = MemValid && !MemReady;
            prev_addr  = MemAddress;
            prev_data  = MemWriteData;
            prev_be    = MemByteEnable;
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((Busy || sb.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n < 50), 32'd1);
    endtask

    task automatic drive(input truncSrc s, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk); #1;
        StoreValid = 1'b1;
        StoreSize  = s;
        Address    = a;
        StoreData  = d;
        @(posedge clk); #1;
        StoreValid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        if (!v.fault) begin
            sb.push_back(v.b0);
            if (v.nbeats == 2) sb.push_back(v.b1);
        end
        drive(v.size, v.addr, v.data);
        chk("fault_flag", 32'(MisalignedFault), 32'(v.fault));
        if (v.fault) begin
            chk("fault_no_valid", 32'(MemValid), 32'd0);
            @(posedge clk); #1;
            chk("fault_pulse_end", 32'(MisalignedFault), 32'd0);
            chk("fault_no_valid2", 32'(MemValid), 32'd0);
            chk("fault_ready", 32'(StoreReady), 32'd1);
        end
        drain("drain_timeout");
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(StoreReady), 32'd1);
        chk({tag, "_valid"}, 32'(MemValid), 32'd0);
        chk({tag, "_addr"}, MemAddress, 32'd0);
        chk({tag, "_data"}, MemWriteData, 32'd0);
        chk({tag, "_be"}, 32'(MemByteEnable), 32'd0);
        chk({tag, "_fault"}, 32'(MisalignedFault), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        StoreValid = 1'b0;
        StoreSize  = WORD;
        Address    = '0;
        StoreData  = '0;
        MemReady   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        vecs.push_back(mk(BYTE, 32'h1003, 32'hAABBCCDD, 0, 1,
            32'h1000, 32'hDD000000, 4'b1000, 0, 0, 0));
        vecs.push_back(mk(BYTE, 32'h1000, 32'h12345678, 0, 1,
            32'h1000, 32'h00000078, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(HALF_WORD, 32'h2000, 32'h1234BEEF, 0, 1,
            32'h2000, 32'h0000BEEF, 4'b0011, 0, 0, 0));
        vecs.push_back(mk(WORD, 32'h4000, 32'hCAFEF00D, 0, 1,
            32'h4000, 32'hCAFEF00D, 4'b1111, 0, 0, 0));
        vecs.push_back(mk(NO_TRUNC, 32'h5004, 32'h01020304, 0, 1,
            32'h5004, 32'h01020304, 4'b1111, 0, 0, 0));
        vecs.push_back(mk(BYTE_UNSIGNED, 32'h6002, 32'hFFFFFF5A, 0, 1,
            32'h6000, 32'h005A0000, 4'b0100, 0, 0, 0));
        vecs.push_back(mk(HALF_WORD_UNSIGNED, 32'h7002, 32'hDEADA5A5, 0, 1,
            32'h7000, 32'hA5A50000, 4'b1100, 0, 0, 0));
`ifdef MISALIGNED_SPLIT_EN
        vecs.push_back(mk(WORD, 32'h3003, 32'h11223344, 0, 2,
            32'h3000, 32'h44000000, 4'b1000,
            32'h3004, 32'h00112233, 4'b0111));
        vecs.push_back(mk(HALF_WORD, 32'h2001, 32'h1234BEEF, 0, 1,
            32'h2000, 32'h00BEEF00, 4'b0110, 0, 0, 0));
        vecs.push_back(mk(WORD, 32'hFFFFFFFE, 32'h11223344, 0, 2,
            32'hFFFFFFFC, 32'h33440000, 4'b1100,
            32'h00000000, 32'h00001122, 4'b0011));
`else
        vecs.push_back(mk(WORD, 32'h3001, 32'h11223344, 1, 0,
            0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(HALF_WORD, 32'h2001, 32'h1234BEEF, 1, 0,
            0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(NO_TRUNC, 32'h1002, 32'h55667788, 1, 0,
            0, 0, 0, 0, 0, 0));
`endif

        foreach (vecs[i]) run_vec(vecs[i]);

        // Half store held under a three-cycle memory stall.
        MemReady = 1'b0;
        sb.push_back('{addr: 32'h2000, data: 32'hBEEF0000, be: 4'b1100});
        drive(HALF_WORD, 32'h2002, 32'h1234BEEF);
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(MemValid), 32'd1);
            chk("stall_data", MemWriteData, 32'hBEEF0000);
            chk("stall_be", 32'(MemByteEnable), 32'hC);
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        MemReady = 1'b1;
        drain("stall_drain_timeout");

        // Reset while beat 0 is still pending.
        MemReady = 1'b0;
        drive(WORD, 32'h4000, 32'h0BADF00D);
        chk("pend_valid", 32'(MemValid), 32'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        MemReady = 1'b1;
        chk_idle("mid_reset");
        @(posedge clk); #1;
        chk_idle("post_reset");

        // Store right after reset recovery still completes normally.
        run_vec(mk(BYTE, 32'h8001, 32'h000000A7, 0, 1,
            32'h8000, 32'h0000A700, 4'b0010, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
